// File: rtl/lcd_pkg.sv
// Shared types and helpers for the HD44780-compatible LCD responder.
package lcd_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CLEAR} state_e;

    typedef enum logic [3:0] {
        CMD_NONE, CMD_WRITE, CMD_READ, CMD_SET_DD, CMD_SET_CG, CMD_FUNC,
        CMD_SHIFT, CMD_DISP, CMD_ENTRY, CMD_HOME, CMD_CLEAR
    } cmd_e;

    localparam int         DD_DEPTH = 128;
    localparam int         DD_AW    = 7;
    localparam logic [7:0] DD_BLANK = 8'h20;

    function automatic int ns2cyc(input int t_ns, input int t_period_ns);
        return t_ns / t_period_ns;
    endfunction

    function automatic logic [DD_AW-1:0] ac_step(input logic [DD_AW-1:0] ac, input logic inc);
        return inc ? ac + 7'd1 : ac - 7'd1;
    endfunction

    // Leading-one decode; a BF read (RS=0,RW=1) and 8'h00 map to CMD_NONE.
    function automatic cmd_e cmd_decode(input logic rs, input logic rw, input logic [7:0] d);
        cmd_e c;
        c = CMD_NONE;
        if (rs) begin
            c = rw ? CMD_READ : CMD_WRITE;
        end else if (!rw) begin
            casez (d)
                8'b1???????: c = CMD_SET_DD;
                8'b01??????: c = CMD_SET_CG;
                8'b001?????: c = CMD_FUNC;
                8'b0001????: c = CMD_SHIFT;
                8'b00001???: c = CMD_DISP;
                8'b000001??: c = CMD_ENTRY;
                8'b0000001?: c = CMD_HOME;
                8'b00000001: c = CMD_CLEAR;
                default:     c = CMD_NONE;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 128x8 display data RAM: one synchronous write port, two asynchronous read ports.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [DD_AW-1:0] i_waddr,
    input  logic [7:0]       i_wdata,
    input  logic [DD_AW-1:0] i_raddr_a,
    output logic [7:0]       o_rdata_a,
    input  logic [DD_AW-1:0] i_raddr_b,
    output logic [7:0]       o_rdata_b
);

    logic [7:0] mem_q [DD_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) mem_q[i_waddr] <= i_wdata;
    end

    assign o_rdata_a = mem_q[i_raddr_a];
    assign o_rdata_b = mem_q[i_raddr_b];

endmodule

// File: rtl/lcd_hd44780_rsp.sv
// Panel-side HD44780 bus responder. Optional EN timing checker: define LCD_RSP_TIMING_CHK_EN.
module lcd_hd44780_rsp
    import lcd_pkg::*;
#(
    parameter int T_PERIOD_NS   = 20,
    parameter int T_EXEC_NS     = 40000,
    parameter int T_CLEAR_NS    = 1600000,
    parameter int T_PW_MIN_NS   = 230,
    parameter int T_CYCE_MIN_NS = 500
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_lcd_data,
    input  logic       i_lcd_rw,
    input  logic       i_lcd_rs,
    input  logic       i_lcd_en,
    input  logic       i_lcd_on,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_data_oe,
    input  logic [6:0] i_dd_raddr,
    output logic [7:0] o_dd_rdata,
    output logic       o_busy,
    output logic [6:0] o_ac,
    output logic [2:0] o_disp,
    output logic [1:0] o_entry,
    output logic [2:0] o_func,
    output logic       o_timing_err
);

    localparam int              CNT_W      = 24;
    localparam logic [CNT_W-1:0] C_EXEC     = CNT_W'(ns2cyc(T_EXEC_NS, T_PERIOD_NS));
    localparam logic [CNT_W-1:0] C_LONG     = CNT_W'(ns2cyc(T_CLEAR_NS, T_PERIOD_NS));
    localparam logic [CNT_W-1:0] C_FILL_REM = C_LONG - CNT_W'(DD_DEPTH);

    logic [7:0]       data_s1_q;
    logic             rw_s1_q, rs_s1_q, en_s1_q, on_s1_q, en_s2_q;
    logic [7:0]       lat_data_q, lat_data_d;
    logic             lat_rs_q, lat_rs_d, lat_rw_q, lat_rw_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, lim_q, lim_d;
    logic [6:0]       ac_q, ac_d;
    logic [2:0]       disp_q, disp_d, func_q, func_d;
    logic [1:0]       entry_q, entry_d;
    logic             oe_q, oe_d;
    logic [7:0]       rdata_q, rdata_d;

    logic             rise, fall, busy, we;
    logic [6:0]       waddr;
    logic [7:0]       wdata, dd_rdata_a;
    cmd_e             cmd;

    assign rise = on_s1_q & en_s1_q & ~en_s2_q;
    assign fall = on_s1_q & ~en_s1_q & en_s2_q;
    assign busy = (state_q != ST_IDLE);
    assign cmd  = cmd_decode(lat_rs_q, lat_rw_q, lat_data_q);

    lcd_ddram u_ddram (
        .i_clk     (i_clk),
        .i_we      (we),
        .i_waddr   (waddr),
        .i_wdata   (wdata),
        .i_raddr_a (ac_q),
        .o_rdata_a (dd_rdata_a),
        .i_raddr_b (i_dd_raddr),
        .o_rdata_b (o_dd_rdata)
    );

    always_comb begin
        lat_data_d = lat_data_q;
        lat_rs_d   = lat_rs_q;
        lat_rw_d   = lat_rw_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        lim_d      = lim_q;
        ac_d       = ac_q;
        disp_d     = disp_q;
        entry_d    = entry_q;
        func_d     = func_q;
        oe_d       = oe_q;
        rdata_d    = rdata_q;
        we         = 1'b0;
        waddr      = ac_q;
        wdata      = lat_data_q;

        // Bus fields are held from the last cycle EN was seen high, so decode at the fall is stable.
        if (en_s1_q) begin
            lat_data_d = data_s1_q;
            lat_rs_d   = rs_s1_q;
            lat_rw_d   = rw_s1_q;
        end

        if (!on_s1_q) begin
            oe_d = 1'b0;
        end else if (rise && rw_s1_q) begin
            oe_d    = 1'b1;
            rdata_d = rs_s1_q ? (busy ? 8'h00 : dd_rdata_a) : {busy, ac_q};
        end else if (fall) begin
            oe_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (fall && cmd != CMD_NONE) begin
                    state_d = ST_EXEC;
                    cnt_d   = '0;
                    lim_d   = C_EXEC;
                    case (cmd)
                        CMD_WRITE: begin
                            we   = 1'b1;
                            ac_d = ac_step(ac_q, entry_q[1]);
                        end
                        CMD_READ:   ac_d = ac_step(ac_q, entry_q[1]);
                        CMD_SET_DD: ac_d = lat_data_q[6:0];
                        CMD_FUNC:   func_d = lat_data_q[4:2];
                        CMD_SHIFT:  if (!lat_data_q[3]) ac_d = ac_step(ac_q, lat_data_q[2]);
                        CMD_DISP:   disp_d = lat_data_q[2:0];
                        CMD_ENTRY:  entry_d = lat_data_q[1:0];
                        CMD_HOME: begin
                            ac_d  = '0;
                            lim_d = C_LONG;
                        end
                        CMD_CLEAR: begin
                            state_d    = ST_CLEAR;
                            ac_d       = '0;
                            entry_d[1] = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_EXEC: begin
                if (cnt_q == lim_q - CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CLEAR: begin
                // Fill cycles are part of the long busy window; the EXEC tail covers the rest.
                we    = 1'b1;
                waddr = cnt_q[6:0];
                wdata = DD_BLANK;
                if (cnt_q[6:0] == 7'h7F) begin
                    state_d = ST_EXEC;
                    cnt_d   = '0;
                    lim_d   = C_FILL_REM;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            data_s1_q  <= '0;
            rw_s1_q    <= 1'b0;
            rs_s1_q    <= 1'b0;
            en_s1_q    <= 1'b0;
            on_s1_q    <= 1'b0;
            en_s2_q    <= 1'b0;
            lat_data_q <= '0;
            lat_rs_q   <= 1'b0;
            lat_rw_q   <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            lim_q      <= '0;
            ac_q       <= '0;
            disp_q     <= '0;
            entry_q    <= 2'b10;
            func_q     <= '0;
            oe_q       <= 1'b0;
            rdata_q    <= '0;
        end else begin
            data_s1_q  <= i_lcd_data;
            rw_s1_q    <= i_lcd_rw;
            rs_s1_q    <= i_lcd_rs;
            en_s1_q    <= i_lcd_en;
            on_s1_q    <= i_lcd_on;
            en_s2_q    <= en_s1_q;
            lat_data_q <= lat_data_d;
            lat_rs_q   <= lat_rs_d;
            lat_rw_q   <= lat_rw_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lim_q      <= lim_d;
            ac_q       <= ac_d;
            disp_q     <= disp_d;
            entry_q    <= entry_d;
            func_q     <= func_d;
            oe_q       <= oe_d;
            rdata_q    <= rdata_d;
        end
    end

    assign o_lcd_data    = rdata_q;
    assign o_lcd_data_oe = oe_q;
    assign o_busy        = busy;
    assign o_ac          = ac_q;
    assign o_disp        = disp_q;
    assign o_entry       = entry_q;
    assign o_func        = func_q;

`ifdef LCD_RSP_TIMING_CHK_EN
    localparam logic [CNT_W-1:0] C_PW_MIN   = CNT_W'(ns2cyc(T_PW_MIN_NS, T_PERIOD_NS));
    localparam logic [CNT_W-1:0] C_CYCE_MIN = CNT_W'(ns2cyc(T_CYCE_MIN_NS, T_PERIOD_NS));

    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d, rr_cnt_q, rr_cnt_d;
    logic             rose_q, rose_d, terr_q, terr_d;

    always_comb begin
        hi_cnt_d = hi_cnt_q;
        rr_cnt_d = rr_cnt_q;
        rose_d   = rose_q;
        terr_d   = terr_q;
        if (rr_cnt_q != '1) rr_cnt_d = rr_cnt_q + CNT_W'(1);
        if (en_s1_q && hi_cnt_q != '1) hi_cnt_d = hi_cnt_q + CNT_W'(1);
        if (rise) begin
            hi_cnt_d = CNT_W'(1);
            rr_cnt_d = CNT_W'(1);
            rose_d   = 1'b1;
            if (rose_q && rr_cnt_q < C_CYCE_MIN) terr_d = 1'b1;
        end
        if (fall && hi_cnt_q < C_PW_MIN) terr_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hi_cnt_q <= '0;
            rr_cnt_q <= '0;
            rose_q   <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            hi_cnt_q <= hi_cnt_d;
            rr_cnt_q <= rr_cnt_d;
            rose_q   <= rose_d;
            terr_q   <= terr_d;
        end
    end

    assign o_timing_err = terr_q;
`else
    assign o_timing_err = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_hd44780_rsp.sv
// Directed, table-driven bench for lcd_hd44780_rsp (C_EXEC=10, C_LONG=200 via parameters).
module tb_lcd_hd44780_rsp;

    localparam int C_EXEC = 10;
    localparam int C_LONG = 200;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] lcd_data;
    logic       lcd_rw, lcd_rs, lcd_en, lcd_on;
    logic [6:0] dd_raddr;
    logic [7:0] o_lcd_data, o_dd_rdata;
    logic       o_lcd_data_oe, o_busy, o_timing_err;
    logic [6:0] o_ac;
    logic [2:0] o_disp, o_func;
    logic [1:0] o_entry;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_hd44780_rsp #(
        .T_PERIOD_NS (20),
        .T_EXEC_NS   (C_EXEC * 20),
        .T_CLEAR_NS  (C_LONG * 20)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_lcd_data    (lcd_data),
        .i_lcd_rw      (lcd_rw),
        .i_lcd_rs      (lcd_rs),
        .i_lcd_en      (lcd_en),
        .i_lcd_on      (lcd_on),
        .o_lcd_data    (o_lcd_data),
        .o_lcd_data_oe (o_lcd_data_oe),
        .i_dd_raddr    (dd_raddr),
        .o_dd_rdata    (o_dd_rdata),
        .o_busy        (o_busy),
        .o_ac          (o_ac),
        .o_disp        (o_disp),
        .o_entry       (o_entry),
        .o_func        (o_func),
        .o_timing_err  (o_timing_err)
    );

    typedef struct {
        string      name;
        logic       rs;
        logic       rw;
        logic [7:0] d;
        logic       chk_rd;
        logic [7:0] exp_rd;
        logic [6:0] exp_ac;
        int         exp_busy;
        logic [2:0] exp_disp;
        logic [1:0] exp_entry;
        logic [2:0] exp_func;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic xfer(input logic rs, input logic rw, input logic [7:0] d, input int hi,
                        output logic [7:0] rd, output logic oe_seen);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
        repeat (hi) @(negedge clk);
        rd = o_lcd_data;
        oe_seen = o_lcd_data_oe;
        lcd_en = 1'b0;
    endtask

    task automatic busy_start(output int t0);
        int t;
        t = 0;
        while (!o_busy && t < 8) begin
            @(negedge clk);
            t++;
        end
        t0 = o_busy ? cyc : -1;
    endtask

    task automatic busy_len(input int t0, output int n);
        int t;
        t = 0;
        if (t0 < 0) begin
            n = 0;
        end else begin
            while (o_busy && t < 1000) begin
                @(negedge clk);
                t++;
            end
            n = o_busy ? -1 : cyc - t0;
        end
    endtask

    task automatic op(input logic rs, input logic rw, input logic [7:0] d, output int n);
        logic [7:0] rd;
        logic       oe;
        int         t0;
        xfer(rs, rw, d, 3, rd, oe);
        busy_start(t0);
        busy_len(t0, n);
    endtask

    task automatic rd_dd(input logic [6:0] a, output logic [7:0] v);
        dd_raddr = a;
        #1;
        v = o_dd_rdata;
    endtask

    initial begin
        logic [7:0] rd, v;
        logic       oe;
        int         t0, n, bad;

        rst_n = 1'b0; lcd_data = '0; lcd_rw = 1'b0; lcd_rs = 1'b0; lcd_en = 1'b0;
        lcd_on = 1'b1; dd_raddr = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_busy",  o_busy, 0);
        chk("rst_ac",    o_ac, 0);
        chk("rst_disp",  o_disp, 0);
        chk("rst_entry", o_entry, 2'b10);
        chk("rst_func",  o_func, 0);
        chk("rst_oe",    o_lcd_data_oe, 0);
        chk("rst_data",  o_lcd_data, 0);
        chk("rst_terr",  o_timing_err, 0);

        // BF read right after reset
        xfer(1'b0, 1'b1, 8'h00, 3, rd, oe);
        chk("bf0_data", rd, 8'h00);
        chk("bf0_oe_hi", oe, 1);
        repeat (2) @(negedge clk);
        chk("bf0_oe_lo", o_lcd_data_oe, 0);

        //        name     rs    rw    d      chk   rd     ac     busy    disp    entry  func
        vt[0]  = '{"wr_A",  1'b1, 1'b0, 8'h41, 1'b0, 8'h00, 7'h01, C_EXEC, 3'b000, 2'b10, 3'b000};
        vt[1]  = '{"wr_B",  1'b1, 1'b0, 8'h42, 1'b0, 8'h00, 7'h02, C_EXEC, 3'b000, 2'b10, 3'b000};
        vt[2]  = '{"set85", 1'b0, 1'b0, 8'h85, 1'b0, 8'h00, 7'h05, C_EXEC, 3'b000, 2'b10, 3'b000};
        vt[3]  = '{"func",  1'b0, 1'b0, 8'h3C, 1'b0, 8'h00, 7'h05, C_EXEC, 3'b000, 2'b10, 3'b111};
        vt[4]  = '{"disp",  1'b0, 1'b0, 8'h0E, 1'b0, 8'h00, 7'h05, C_EXEC, 3'b110, 2'b10, 3'b111};
        vt[5]  = '{"shR",   1'b0, 1'b0, 8'h14, 1'b0, 8'h00, 7'h06, C_EXEC, 3'b110, 2'b10, 3'b111};
        vt[6]  = '{"shL",   1'b0, 1'b0, 8'h10, 1'b0, 8'h00, 7'h05, C_EXEC, 3'b110, 2'b10, 3'b111};
        vt[7]  = '{"shDsp", 1'b0, 1'b0, 8'h1C, 1'b0, 8'h00, 7'h05, C_EXEC, 3'b110, 2'b10, 3'b111};
        vt[8]  = '{"cgram", 1'b0, 1'b0, 8'h40, 1'b0, 8'h00, 7'h05, C_EXEC, 3'b110, 2'b10, 3'b111};
        vt[9]  = '{"set80", 1'b0, 1'b0, 8'h80, 1'b0, 8'h00, 7'h00, C_EXEC, 3'b110, 2'b10, 3'b111};
        vt[10] = '{"rdDD",  1'b1, 1'b1, 8'h00, 1'b1, 8'h41, 7'h01, C_EXEC, 3'b110, 2'b10, 3'b111};
        vt[11] = '{"rdBF",  1'b0, 1'b1, 8'h00, 1'b1, 8'h01, 7'h01, 0,      3'b110, 2'b10, 3'b111};
        vt[12] = '{"home",  1'b0, 1'b0, 8'h02, 1'b0, 8'h00, 7'h00, C_LONG, 3'b110, 2'b10, 3'b111};
        vt[13] = '{"entDn", 1'b0, 1'b0, 8'h04, 1'b0, 8'h00, 7'h00, C_EXEC, 3'b110, 2'b00, 3'b111};
        vt[14] = '{"wr_Z",  1'b1, 1'b0, 8'h5A, 1'b0, 8'h00, 7'h7F, C_EXEC, 3'b110, 2'b00, 3'b111};
        vt[15] = '{"setFF", 1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, 7'h7F, C_EXEC, 3'b110, 2'b00, 3'b111};
        vt[16] = '{"entUp", 1'b0, 1'b0, 8'h06, 1'b0, 8'h00, 7'h7F, C_EXEC, 3'b110, 2'b10, 3'b111};
        vt[17] = '{"wr_33", 1'b1, 1'b0, 8'h33, 1'b0, 8'h00, 7'h00, C_EXEC, 3'b110, 2'b10, 3'b111};
        vt[18] = '{"nop00", 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 7'h00, 0,      3'b110, 2'b10, 3'b111};

        for (int i = 0; i < 19; i++) begin
            xfer(vt[i].rs, vt[i].rw, vt[i].d, 3, rd, oe);
            busy_start(t0);
            busy_len(t0, n);
            if (vt[i].chk_rd) begin
                chk({vt[i].name, "_rd"}, rd, vt[i].exp_rd);
                chk({vt[i].name, "_oe"}, oe, 1);
            end
            chk({vt[i].name, "_busy"},  n, vt[i].exp_busy);
            chk({vt[i].name, "_ac"},    o_ac, vt[i].exp_ac);
            chk({vt[i].name, "_disp"},  o_disp, vt[i].exp_disp);
            chk({vt[i].name, "_entry"}, o_entry, vt[i].exp_entry);
            chk({vt[i].name, "_func"},  o_func, vt[i].exp_func);
        end
        rd_dd(7'h00, v); chk("dd00", v, 8'h5A);
        rd_dd(7'h01, v); chk("dd01", v, 8'h42);
        rd_dd(7'h7F, v); chk("dd7F", v, 8'h33);

        // Clear with accesses during busy
        op(1'b0, 1'b0, 8'h04, n);
        op(1'b0, 1'b0, 8'hB0, n);
        chk("pre_clr_ac", o_ac, 7'h30);
        xfer(1'b0, 1'b0, 8'h01, 3, rd, oe);
        busy_start(t0);
        xfer(1'b1, 1'b0, 8'h51, 3, rd, oe);
        xfer(1'b0, 1'b1, 8'h00, 3, rd, oe);
        chk("clr_bf_rd", rd, 8'h80);
        busy_len(t0, n);
        chk("clr_busy", n, C_LONG);
        chk("clr_ac", o_ac, 0);
        chk("clr_entry", o_entry, 2'b10);
        bad = 0;
        for (int a = 0; a < 128; a++) begin
            rd_dd(7'(a), v);
            if (v !== 8'h20) bad++;
        end
        chk("clr_fill_bad", bad, 0);

        // Reset in the middle of a clear
        op(1'b0, 1'b0, 8'hF0, n);
        op(1'b1, 1'b0, 8'h77, n);
        op(1'b0, 1'b0, 8'h85, n);
        chk("pre_rst_ac", o_ac, 7'h05);
        xfer(1'b0, 1'b0, 8'h01, 3, rd, oe);
        busy_start(t0);
        chk("mid_clr_busy", o_busy, 1);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rstmid_busy", o_busy, 0);
        chk("rstmid_ac", o_ac, 0);
        rd_dd(7'h70, v); chk("rstmid_dd70", v, 8'h77);
        op(1'b1, 1'b0, 8'h4D, n);
        chk("post_rst_busy", n, C_EXEC);
        chk("post_rst_ac", o_ac, 7'h01);
        rd_dd(7'h00, v); chk("post_rst_dd00", v, 8'h4D);

        // Panel off: bus ignored
        lcd_on = 1'b0;
        repeat (3) @(negedge clk);
        op(1'b1, 1'b0, 8'h55, n);
        chk("off_busy", n, 0);
        chk("off_ac", o_ac, 7'h01);
        rd_dd(7'h01, v); chk("off_dd01", v, 8'h20);
        xfer(1'b0, 1'b1, 8'h00, 3, rd, oe);
        chk("off_oe", oe, 0);
        lcd_on = 1'b1;
        repeat (3) @(negedge clk);

        // EN timing checker
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
`ifdef LCD_RSP_TIMING_CHK_EN
        xfer(1'b0, 1'b0, 8'h0C, 12, rd, oe);
        busy_start(t0); busy_len(t0, n);
        repeat (30) @(negedge clk);
        xfer(1'b0, 1'b0, 8'h0E, 12, rd, oe);
        busy_start(t0); busy_len(t0, n);
        chk("terr_legal", o_timing_err, 0);
        chk("terr_legal_disp", o_disp, 3'b110);
        repeat (30) @(negedge clk);
        xfer(1'b0, 1'b0, 8'h0C, 5, rd, oe);
        busy_start(t0); busy_len(t0, n);
        chk("terr_short", o_timing_err, 1);
        chk("terr_short_exec", o_disp, 3'b100);
        repeat (30) @(negedge clk);
        xfer(1'b0, 1'b0, 8'h0E, 12, rd, oe);
        busy_start(t0); busy_len(t0, n);
        chk("terr_sticky", o_timing_err, 1);
`else
        xfer(1'b0, 1'b0, 8'h0C, 5, rd, oe);
        busy_start(t0); busy_len(t0, n);
        chk("terr_off", o_timing_err, 0);
        chk("terr_off_disp", o_disp, 3'b100);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
